// File: rtl/keypad_scan_history_pkg.sv
// Shared types and helpers for the keypad scanner: FSM state encoding,
// the 4x4 hex key map and a population-count helper for column patterns.
package kp_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2,
        RELEASE  = 2'd3
    } kp_state_e;

    // Physical key layout of the legacy 4x4 pad, row-major.
    function automatic logic [3:0] kp_hex(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] code;
        case ({row, col})
            4'h0: code = 4'h1;
            4'h1: code = 4'h2;
            4'h2: code = 4'h3;
            4'h3: code = 4'hA;
            4'h4: code = 4'h4;
            4'h5: code = 4'h5;
            4'h6: code = 4'h6;
            4'h7: code = 4'hB;
            4'h8: code = 4'h7;
            4'h9: code = 4'h8;
            4'hA: code = 4'h9;
            4'hB: code = 4'hC;
            4'hC: code = 4'hE;
            4'hD: code = 4'h0;
            4'hE: code = 4'hF;
            4'hF: code = 4'hD;
            default: code = 4'h0;
        endcase
        return code;
    endfunction

    function automatic logic [5:0] onehot_count(input logic [31:0] vec);
        logic [5:0] cnt;
        cnt = 6'd0;
        for (int i = 0; i < 32; i++) begin
            cnt = cnt + 6'(vec[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/keypad_scan_history_fsm.sv
// Row scanning, column synchronisation, press/release debounce state machine.
// Emits single-cycle accept/release strobes and the latched key position.
module keypad_debounce_fsm
    import kp_pkg::*;
#(
    parameter int NROWS           = 4,
    parameter int NCOLS           = 4,
    parameter int SCAN_CYCLES     = 4,
    parameter int DEBOUNCE_CYCLES = 20000,
    localparam int RW = $clog2(NROWS),
    localparam int CW = $clog2(NCOLS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NCOLS-1:0] cols,
    output logic [NROWS-1:0] rows,
    output logic [RW-1:0]    key_row,
    output logic [CW-1:0]    key_col,
    output logic             accept,
    output logic             key_release,
    output logic             multi_key
);

    localparam int SW = $clog2(SCAN_CYCLES);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);

    kp_state_e        state_r, state_n_s;
    logic [NCOLS-1:0] sync_r, cs_r, lat_cols_r, lat_cols_n_s, low_s;
    logic [RW-1:0]    row_r, row_n_s, row_next_s;
    logic [CW-1:0]    col_r, col_n_s, col_found_s;
    logic [SW-1:0]    scan_cnt_r, scan_cnt_n_s;
    logic [DW-1:0]    deb_cnt_r, deb_cnt_n_s, deb_inc_s;
    logic [NROWS-1:0] rows_r;
    logic             multi_r, multi_s, accept_s, release_s;
    logic [5:0]       low_cnt_s;
    logic             all_high_s;

    assign low_s      = ~cs_r;
    assign low_cnt_s  = onehot_count(32'(low_s));
    assign all_high_s = &cs_r;
    assign row_next_s = (row_r == RW'(NROWS - 1)) ? RW'(0) : row_r + RW'(1);
    assign deb_inc_s  = (deb_cnt_r == DW'(DEBOUNCE_CYCLES)) ? deb_cnt_r : deb_cnt_r + DW'(1);

    // Lowest low column of the current sample; only used when exactly one is low.
    always_comb begin
        col_found_s = CW'(0);
        for (int i = NCOLS - 1; i >= 0; i--) begin
            col_found_s = cs_r[i] ? col_found_s : CW'(i);
        end
    end

    // Next-state logic: scanning, debounce counting and event strobes.
    always_comb begin
        state_n_s    = state_r;
        row_n_s      = row_r;
        col_n_s      = col_r;
        lat_cols_n_s = lat_cols_r;
        scan_cnt_n_s = scan_cnt_r;
        deb_cnt_n_s  = deb_cnt_r;
        accept_s     = 1'b0;
        release_s    = 1'b0;
        multi_s      = 1'b0;
        case (state_r)
            SCAN: begin
                if (scan_cnt_r == SW'(SCAN_CYCLES - 1)) begin
                    scan_cnt_n_s = SW'(0);
                    if (low_cnt_s == 6'd0) begin
                        row_n_s = row_next_s;
                    end else if (low_cnt_s == 6'd1) begin
                        lat_cols_n_s = cs_r;
                        col_n_s      = col_found_s;
                        deb_cnt_n_s  = DW'(0);
                        state_n_s    = DEBOUNCE;
                    end else begin
                        multi_s = 1'b1;
                        row_n_s = row_next_s;
                    end
                end else begin
                    scan_cnt_n_s = scan_cnt_r + SW'(1);
                end
            end
            DEBOUNCE: begin
                if (cs_r == lat_cols_r) begin
                    if (deb_inc_s == DW'(DEBOUNCE_CYCLES)) begin
                        accept_s    = 1'b1;
                        deb_cnt_n_s = DW'(0);
                        state_n_s   = HELD;
                    end else begin
                        deb_cnt_n_s = deb_inc_s;
                    end
                end else begin
                    deb_cnt_n_s  = DW'(0);
                    scan_cnt_n_s = SW'(0);
                    row_n_s      = row_next_s;
                    state_n_s    = SCAN;
                end
            end
            HELD: begin
                // Extra keys on the held row are deliberately ignored here.
                if (all_high_s) begin
                    deb_cnt_n_s = DW'(0);
                    state_n_s   = RELEASE;
                end else begin
                    state_n_s = HELD;
                end
            end
            RELEASE: begin
                if (all_high_s) begin
                    if (deb_inc_s == DW'(DEBOUNCE_CYCLES)) begin
                        release_s    = 1'b1;
                        deb_cnt_n_s  = DW'(0);
                        scan_cnt_n_s = SW'(0);
                        row_n_s      = row_next_s;
                        state_n_s    = SCAN;
                    end else begin
                        deb_cnt_n_s = deb_inc_s;
                    end
                end else begin
                    deb_cnt_n_s = DW'(0);
                    state_n_s   = HELD;
                end
            end
            default: begin
                deb_cnt_n_s  = DW'(0);
                scan_cnt_n_s = SW'(0);
                state_n_s    = SCAN;
            end
        endcase
    end

    // State, counters, synchroniser and registered row drive.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r    <= SCAN;
            sync_r     <= {NCOLS{1'b1}};
            cs_r       <= {NCOLS{1'b1}};
            lat_cols_r <= {NCOLS{1'b1}};
            row_r      <= RW'(0);
            col_r      <= CW'(0);
            scan_cnt_r <= SW'(0);
            deb_cnt_r  <= DW'(0);
            rows_r     <= ~NROWS'(1);
            multi_r    <= 1'b0;
        end else begin
            state_r    <= state_n_s;
            sync_r     <= cols;
            cs_r       <= sync_r;
            lat_cols_r <= lat_cols_n_s;
            row_r      <= row_n_s;
            col_r      <= col_n_s;
            scan_cnt_r <= scan_cnt_n_s;
            deb_cnt_r  <= deb_cnt_n_s;
            rows_r     <= ~(NROWS'(1) << row_n_s);
            multi_r    <= multi_s;
        end
    end

    assign rows        = rows_r;
    assign key_row     = row_r;
    assign key_col     = col_r;
    assign accept      = accept_s;
    assign key_release = release_s;
    assign multi_key   = multi_r;

endmodule

// File: rtl/keypad_scan_history.sv
// Keypad scanner top: maps the accepted key position to a code and keeps
// the last accepted code plus a DEPTH-entry history of recent keys.
module keypad_scan_history
    import kp_pkg::*;
#(
    parameter int NROWS           = 4,
    parameter int NCOLS           = 4,
    parameter int SCAN_CYCLES     = 4,
    parameter int DEBOUNCE_CYCLES = 20000,
    parameter int DEPTH           = 2,
    parameter int MAP_HEX         = 1,
    localparam int CODE_W = (MAP_HEX == 1) ? 4 : $clog2(NROWS * NCOLS)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NCOLS-1:0]        cols,
    output logic [NROWS-1:0]        rows,
    input  logic                    clear,
    output logic                    key_valid,
    output logic [CODE_W-1:0]       key_code,
    output logic                    key_held,
    output logic                    multi_key,
    output logic [DEPTH*CODE_W-1:0] history
);

    localparam int RW     = $clog2(NROWS);
    localparam int CW     = $clog2(NCOLS);
    localparam int HIST_W = DEPTH * CODE_W;

    if (NROWS < 2) begin : g_bad_nrows
        $error("keypad_scan_history: NROWS must be >= 2");
    end
    if (NCOLS < 2) begin : g_bad_ncols
        $error("keypad_scan_history: NCOLS must be >= 2");
    end
    if (SCAN_CYCLES < 3) begin : g_bad_scan
        $error("keypad_scan_history: SCAN_CYCLES must be >= 3");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_deb
        $error("keypad_scan_history: DEBOUNCE_CYCLES must be >= 1");
    end
    if (DEPTH < 1) begin : g_bad_depth
        $error("keypad_scan_history: DEPTH must be >= 1");
    end
    if (MAP_HEX == 1 && (NROWS != 4 || NCOLS != 4)) begin : g_bad_map
        $error("keypad_scan_history: MAP_HEX requires a 4x4 keypad");
    end

    logic [RW-1:0]     row_s;
    logic [CW-1:0]     col_s;
    logic              accept_s, release_s, multi_s;
    logic [CODE_W-1:0] code_s;
    logic [HIST_W-1:0] shifted_s;
    logic              key_valid_r, key_held_r;
    logic [CODE_W-1:0] key_code_r;
    logic [HIST_W-1:0] history_r;

    keypad_debounce_fsm #(
        .NROWS          (NROWS),
        .NCOLS          (NCOLS),
        .SCAN_CYCLES    (SCAN_CYCLES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_fsm (
        .clk        (clk),
        .reset      (reset),
        .cols       (cols),
        .rows       (rows),
        .key_row    (row_s),
        .key_col    (col_s),
        .accept     (accept_s),
        .key_release(release_s),
        .multi_key  (multi_s)
    );

    if (MAP_HEX == 1) begin : g_hex
        assign code_s = kp_hex(2'(row_s), 2'(col_s));
    end else begin : g_raw
        assign code_s = CODE_W'(int'(row_s) * NCOLS + int'(col_s));
    end

    if (DEPTH == 1) begin : g_hist1
        assign shifted_s = code_s;
    end else begin : g_histn
        assign shifted_s = {history_r[(DEPTH-1)*CODE_W-1:0], code_s};
    end

    // Output registers: event pulse, last code, held flag and key history.
    always_ff @(posedge clk) begin
        if (!reset) begin
            key_valid_r <= 1'b0;
            key_held_r  <= 1'b0;
            key_code_r  <= CODE_W'(0);
            history_r   <= HIST_W'(0);
        end else begin
            key_valid_r <= accept_s;
            if (accept_s) begin
                key_code_r <= code_s;
                key_held_r <= 1'b1;
            end else if (release_s) begin
                key_code_r <= key_code_r;
                key_held_r <= 1'b0;
            end else begin
                key_code_r <= key_code_r;
                key_held_r <= key_held_r;
            end
            // A clear coinciding with a new key keeps only that key.
            if (accept_s) begin
                history_r <= clear ? HIST_W'(code_s) : shifted_s;
            end else if (clear) begin
                history_r <= HIST_W'(0);
            end else begin
                history_r <= history_r;
            end
        end
    end

    assign key_valid = key_valid_r;
    assign key_held  = key_held_r;
    assign key_code  = key_code_r;
    assign multi_key = multi_s;
    assign history   = history_r;

endmodule

// File: tb/tb_keypad_scan_history.sv
// Scoreboard bench for keypad_scan_history: a keypad model drives cols from
// rows; expected key events are queued and checked by a separate monitor.
module tb_keypad_scan_history;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        clear = 1'b0;
    logic [3:0]  cols;
    logic [3:0]  rows;
    logic        key_valid, key_held, multi_key;
    logic [3:0]  key_code;
    logic [7:0]  history;

    logic [3:0][3:0] press_m = '0;
    logic [11:0]     exp_q[$];
    int              checks = 0;
    int              failures = 0;
    int              multi_cnt = 0;

    always #5 clk = ~clk;

    keypad_scan_history #(
        .NROWS(4), .NCOLS(4), .SCAN_CYCLES(4), .DEBOUNCE_CYCLES(4), .DEPTH(2), .MAP_HEX(1)
    ) dut (
        .clk(clk), .reset(reset), .cols(cols), .rows(rows), .clear(clear),
        .key_valid(key_valid), .key_code(key_code), .key_held(key_held),
        .multi_key(multi_key), .history(history)
    );

    // Keypad model: a pressed key pulls its column low while its row is driven.
    always_comb begin
        cols = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (press_m[r][c] && !rows[r]) cols[c] = 1'b0;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Monitor: every key_valid pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (reset && multi_key) multi_cnt++;
        if (reset && key_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_key_valid", {key_code, history}, 12'hFFF);
            end else begin
                logic [11:0] e;
                e = exp_q.pop_front();
                check("key_code", key_code, e[11:8]);
                check("history", history, e[7:0]);
            end
        end
    end

    task automatic wait_held(input logic val, input string name);
        int n = 0;
        while (key_held !== val && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(name, key_held, val);
    endtask

    task automatic wait_row(input logic [3:0] pat);
        int n = 0;
        while (rows === pat && n < 100) begin @(negedge clk); n++; end
        while (rows !== pat && n < 100) begin @(negedge clk); n++; end
        check("wait_row", rows, pat);
    endtask

    task automatic press_release(input int r, input int c, input logic [3:0] code, input logic [7:0] hist);
        exp_q.push_back({code, hist});
        press_m[r][c] = 1'b1;
        wait_held(1'b1, "held_rise");
        repeat (10) @(negedge clk);
        press_m[r][c] = 1'b0;
        wait_held(1'b0, "held_fall");
        repeat (5) @(negedge clk);
    endtask

    initial begin
        int n;
        logic [3:0] rot;
        repeat (3) @(negedge clk);
        check("rst_rows", rows, 4'b1110);
        check("rst_history", history, 8'h00);
        check("rst_flags", {key_valid, key_held, multi_key}, 3'b000);
        check("rst_code", key_code, 4'h0);
        reset = 1'b1;
        rot = 4'b1110;
        for (int k = 0; k < 16; k++) begin
            check("rows_rotate", rows, rot);
            @(negedge clk);
            if (k % 4 == 3) rot = {rot[2:0], rot[3]};
        end

        // '8' at row2/col1; key_held falls 2 sync + 1 transition + 4 debounce edges after release.
        exp_q.push_back({4'h8, 8'h08});
        press_m[2][1] = 1'b1;
        wait_held(1'b1, "held_rise_8");
        repeat (10) @(negedge clk);
        press_m[2][1] = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (key_held === 1'b1 && n < 50);
        check("held_release_cycles", n, 7);
        repeat (5) @(negedge clk);

        // Two-cycle glitch straddling the row1 sample: debounce aborts, row 2 follows.
        wait_row(4'b1101);
        @(negedge clk);
        press_m[1][0] = 1'b1;
        repeat (2) @(negedge clk);
        press_m[1][0] = 1'b0;
        repeat (2) @(negedge clk);
        check("glitch_row_held", rows, 4'b1101);
        @(negedge clk);
        check("glitch_next_row", rows, 4'b1011);
        check("glitch_no_held", key_held, 1'b0);

        press_release(0, 0, 4'h1, 8'h81);
        press_release(0, 3, 4'hA, 8'h1A);
        press_release(3, 1, 4'h0, 8'hA0);

        // '5' held, then a second key on the same row, then release both.
        exp_q.push_back({4'h5, 8'h05});
        press_m[1][1] = 1'b1;
        wait_held(1'b1, "held_rise_5");
        repeat (3) @(negedge clk);
        press_m[1][3] = 1'b1;
        repeat (20) @(negedge clk);
        press_m[1][1] = 1'b0;
        press_m[1][3] = 1'b0;
        wait_held(1'b0, "held_fall_5");
        repeat (5) @(negedge clk);
        check("multi_during_hold", multi_cnt, 0);

        // Two columns low on row 0: one multi_key pulse, no key event.
        press_m[0][0] = 1'b1;
        press_m[0][1] = 1'b1;
        n = 0;
        while (multi_key !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        check("multi_seen", multi_key, 1'b1);
        press_m[0][0] = 1'b0;
        press_m[0][1] = 1'b0;
        repeat (40) @(negedge clk);
        check("multi_count", multi_cnt, 1);
        check("multi_no_held", key_held, 1'b0);

        // '7' with clear on the accepting edge: sample 4 edges in, accept 4 later.
        exp_q.push_back({4'h7, 8'h07});
        wait_row(4'b1011);
        press_m[2][0] = 1'b1;
        repeat (7) @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check("clear_valid_edge", key_valid, 1'b1);
        press_m[2][0] = 1'b0;
        wait_held(1'b0, "held_fall_7");
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check("clear_history", history, 8'h00);
        check("clear_keeps_code", key_code, 4'h7);

        // Reset during debounce of 'D' aborts with no event.
        wait_row(4'b0111);
        press_m[3][3] = 1'b1;
        repeat (5) @(negedge clk);
        reset = 1'b0;
        press_m[3][3] = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        check("abort_code", key_code, 4'h0);
        check("abort_rows", rows, 4'b1110);
        check("abort_held", key_held, 1'b0);
        repeat (40) @(negedge clk);

        check("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
